// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream output stage: main register plus one skid entry.
// s_ready is registered so there is no combinational path from m_ready.
module axis_skid_buffer #(
  parameter int unsigned data_width = 17
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  logic [data_width-1:0] main_data_q, main_data_d;
  logic [data_width-1:0] skid_data_q, skid_data_d;
  logic                  main_valid_q, main_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  ready_q;
  logic                  accept;

  assign accept  = s_valid && ready_q;
  assign s_ready = ready_q;
  assign m_data  = main_data_q;
  assign m_valid = main_valid_q;

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // ready is low here, so no new sample can arrive this cycle
      if (m_ready) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || m_ready) begin
        main_data_d  = s_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = s_data;
        skid_valid_d = 1'b1;
      end
    end else if (m_ready) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_lpf_shifted_inverse.sv
// Inverse of the shift-alpha first-order low-pass: x = y_prev + ((y - y_prev) <<< alpha),
// saturated to the signed output range, with a skid-buffered AXI-Stream master.
module axis_lpf_shifted_inverse #(
  parameter int unsigned inout_width         = 16,
  parameter int unsigned inout_decimal_width = 15,
  parameter int unsigned max_shift           = 15
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic [4:0]             i5_alpha,
  input  logic                   i_sat_clear,
  output logic                   o_sat_sticky,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [inout_width-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int unsigned W  = inout_width;
  localparam int unsigned SW = inout_width + 2 + max_shift;

  if (max_shift > 30 || inout_decimal_width >= inout_width) begin : gen_param_check
    $error("axis_lpf_shifted_inverse: bad max_shift or inout_decimal_width");
  end

  // Returns {saturated, result}.
  function automatic logic [W:0] shift_add_sat(input logic [W-1:0] y, input logic [W-1:0] yp,
                                               input logic [4:0] alpha);
    logic signed [W:0]    d;
    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] s;
    logic                 ovf;
    d     = $signed({y[W-1], y}) - $signed({yp[W-1], yp});
    d_ext = $signed({{(SW-W-1){d[W]}}, d});
    s     = $signed({{(SW-W){yp[W-1]}}, yp}) + (d_ext <<< alpha);
    // Fits iff every bit from the output sign bit upward agrees
    ovf   = !((&s[SW-1:W-1]) || !(|s[SW-1:W-1]));
    if (!ovf) return {1'b0, s[W-1:0]};
    else if (s[SW-1]) return {1'b1, 1'b1, {(W-1){1'b0}}};
    else return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  logic [W-1:0] y_prev_q;
  logic         sticky_q;
  logic [4:0]   alpha_eff;
  logic [W:0]   recon;
  logic         accept;

  assign alpha_eff    = (i5_alpha > 5'(max_shift)) ? 5'(max_shift) : i5_alpha;
  assign recon        = shift_add_sat(s_axis_tdata, y_prev_q, alpha_eff);
  assign accept       = s_axis_tvalid && s_axis_tready;
  assign o_sat_sticky = sticky_q;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      y_prev_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (accept) y_prev_q <= s_axis_tdata;
      if (accept && recon[W]) sticky_q <= 1'b1;
      else if (i_sat_clear) sticky_q <= 1'b0;
    end
  end

  axis_skid_buffer #(
    .data_width(W + 1)
  ) u_skid (
    .aclk   (aclk),
    .resetn (resetn),
    .s_data ({s_axis_tlast, recon[W-1:0]}),
    .s_valid(s_axis_tvalid),
    .s_ready(s_axis_tready),
    .m_data ({m_axis_tlast, m_axis_tdata}),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

endmodule

// File: tb/tb_axis_lpf_shifted_inverse.sv
// Bench for axis_lpf_shifted_inverse: directed plan items plus a random phase,
// checked against an arithmetic model with an expected-output queue.
module tb_axis_lpf_shifted_inverse;

  logic        aclk = 1'b0;
  logic        resetn;
  logic [4:0]  i5_alpha;
  logic        i_sat_clear;
  logic        o_sat_sticky;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  axis_lpf_shifted_inverse #(
    .inout_width        (16),
    .inout_decimal_width(15),
    .max_shift          (15)
  ) dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .i5_alpha     (i5_alpha),
    .i_sat_clear  (i_sat_clear),
    .o_sat_sticky (o_sat_sticky),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic [15:0] stim_d[$];
  bit          stim_l[$];
  logic [4:0]  stim_a[$];
  int          y_prev_m = 0;
  bit          sticky_m = 1'b0;
  int          drops = 0;
  bit          last_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // x = y_prev + (y - y_prev) * 2^min(alpha,15), clamped to int16; returns {sat, x}
  function automatic logic [16:0] model(input int y, input int yp, input int a);
    longint s;
    int ae;
    ae = (a > 15) ? 15 : a;
    s = longint'(yp) + longint'(y - yp) * (longint'(1) << ae);
    if (s > 32767) return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  task automatic tick();
    bit          rst_edge, acc, hs, stalled;
    logic [16:0] held, r;
    rst_edge = !resetn;
    acc      = !rst_edge && s_axis_tvalid && s_axis_tready;
    hs       = !rst_edge && m_axis_tvalid && m_axis_tready;
    stalled  = !rst_edge && m_axis_tvalid && !m_axis_tready;
    held     = {m_axis_tlast, m_axis_tdata};
    if (hs) begin
      obs_q.push_back(held);
      if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
      else begin
        check("out_data", 32'(held), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (acc) begin
      r = model(int'($signed(s_axis_tdata)), y_prev_m, int'(i5_alpha));
      exp_q.push_back({s_axis_tlast, r[15:0]});
      y_prev_m = int'($signed(s_axis_tdata));
    end
    if (rst_edge) begin
      exp_q.delete();
      y_prev_m = 0;
      sticky_m = 1'b0;
    end else if (acc && r[16]) sticky_m = 1'b1;
    else if (i_sat_clear) sticky_m = 1'b0;
    @(posedge aclk);
    #1;
    check("s_tready", 32'(s_axis_tready), 32'(!rst_edge && exp_q.size() < 2));
    check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() > 0));
    check("sticky", 32'(o_sat_sticky), 32'(sticky_m));
    if (stalled) check("stall_hold", 32'({m_axis_tlast, m_axis_tdata}), 32'(held));
    if (last_ready && !s_axis_tready && !rst_edge) drops++;
    last_ready = s_axis_tready;
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    i_sat_clear   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    obs_q.delete();
    drops = 0;
  endtask

  // mode 0: m_ready high; 1: m_ready low for cycles 3..5; 2: random m_ready and clear
  task automatic run_stream(input int mode);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while ((idx < stim_d.size() || exp_q.size() > 0) && cyc < 400) begin
      s_axis_tvalid = (idx < stim_d.size());
      s_axis_tdata  = s_axis_tvalid ? stim_d[idx] : 16'h0;
      s_axis_tlast  = s_axis_tvalid ? stim_l[idx] : 1'b0;
      i5_alpha      = s_axis_tvalid ? stim_a[idx] : 5'd0;
      case (mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = !(cyc >= 3 && cyc <= 5);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      i_sat_clear = (mode == 2) && ($urandom_range(0, 7) == 0);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    check("stream_done", 32'(idx == stim_d.size() && exp_q.size() == 0), 32'd1);
    s_axis_tvalid = 1'b0;
    i_sat_clear   = 1'b0;
    stim_d.delete();
    stim_l.delete();
    stim_a.delete();
  endtask

  task automatic push(input logic [15:0] d, input bit l, input logic [4:0] a);
    stim_d.push_back(d);
    stim_l.push_back(l);
    stim_a.push_back(a);
  endtask

  initial begin
    int yl;
    i5_alpha      = 5'd0;
    s_axis_tdata  = 16'h0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    do_reset();

    // 1: basic reconstruction
    push(16'h1000, 1'b0, 5'd2);
    push(16'h1000, 1'b0, 5'd2);
    run_stream(0);
    check("t1_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t1_out0", 32'(obs_q[0]), 32'h4000);
      check("t1_out1", 32'(obs_q[1]), 32'h1000);
    end

    // 2: cascade after the shift-alpha LPF on a 0x4000 step
    do_reset();
    yl = 0;
    for (int i = 0; i < 6; i++) begin
      yl = yl + ((16384 - yl) >>> 2);
      push(16'(yl), 1'b0, 5'd2);
    end
    run_stream(0);
    check("t2_count", obs_q.size(), 6);
    foreach (obs_q[i]) check("t2_out", 32'(obs_q[i]), 32'h4000);
    check("t2_sticky", 32'(o_sat_sticky), 32'd0);

    // 3: saturation both ways, then sticky clear
    do_reset();
    push(16'h7000, 1'b0, 5'd2);
    run_stream(0);
    if (obs_q.size() == 1) check("t3_pos", 32'(obs_q[0]), 32'h7fff);
    check("t3_sticky_set", 32'(o_sat_sticky), 32'd1);
    do_reset();
    push(16'h9000, 1'b0, 5'd2);
    run_stream(0);
    if (obs_q.size() == 1) check("t3_neg", 32'(obs_q[0]), 32'h8000);
    else check("t3_neg_count", obs_q.size(), 1);
    i_sat_clear = 1'b1;
    tick();
    i_sat_clear = 1'b0;
    check("t3_sticky_clr", 32'(o_sat_sticky), 32'd0);

    // 4: backpressure mid-stream
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i * 256), 1'b0, 5'd0);
    run_stream(1);
    check("t4_count", obs_q.size(), 8);
    foreach (obs_q[i]) check("t4_order", 32'(obs_q[i]), 32'((i + 1) * 256));
    check("t4_drops", drops, 1);

    // 5: tlast on 4th of 4 under random ready
    do_reset();
    for (int i = 0; i < 4; i++) push(16'(16'h0040 * (i + 1)), (i == 3), 5'd1);
    run_stream(2);
    check("t5_count", obs_q.size(), 4);
    foreach (obs_q[i]) check("t5_last", 32'(obs_q[i][16]), 32'(i == 3));

    // 6: reset with the skid entry full
    do_reset();
    m_axis_tready = 1'b0;
    s_axis_tdata  = 16'h0100;
    s_axis_tlast  = 1'b0;
    i5_alpha      = 5'd0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_full", 32'(s_axis_tready), 32'd0);
    do_reset();
    push(16'h0800, 1'b0, 5'd1);
    run_stream(0);
    if (obs_q.size() == 1) check("t6_out", 32'(obs_q[0]), 32'h1000);
    else check("t6_count", obs_q.size(), 1);

    // Random phase: random data, alpha (including values above max_shift), ready, clear
    do_reset();
    for (int i = 0; i < 60; i++)
      push(16'($urandom()), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    run_stream(2);
    check("rand_count", obs_q.size(), 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
